e203_dtcm_bank_ram: RTL and testbench

- Parametrised successor to the single-macro DTCM SRAM.
- Splits the DTCM into NB word-interleaved banks, each backed by one sirv_gnrl_ram instance.
- Adds a valid/ready request handshake, a registered read-response flag, and per-bank automatic light-sleep with a timed wake-up.
- Sits between the LSU/ICB DTCM controller and the SRAM macros.

---
 rtl/e203_dtcm_bank_ram_pkg.sv | 20 ++
 rtl/e203_dtcm_bank_pwr.sv | 82 ++++++++
 rtl/sirv_gnrl_ram.sv | 46 ++++
 rtl/e203_dtcm_bank_ram.sv | 109 ++++++++++
 tb/tb_e203_dtcm_bank_ram.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/e203_dtcm_bank_ram_pkg.sv
// Shared DTCM bank definitions: default geometry/timing and bank power-state encoding.
package e203_dtcm_bank_ram_pkg;

  localparam int E203_DTCM_NB       = 4;
  localparam int E203_DTCM_IDLE_CYC = 16;
  localparam int E203_DTCM_WAKE_CYC = 2;

  typedef enum logic [1:0] {
    ST_ACT  = 2'd0,
    ST_SLP  = 2'd1,
    ST_WAKE = 2'd2,
    ST_SD   = 2'd3
  } bank_st_e;

  // Bits needed to hold 0..n, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/e203_dtcm_bank_pwr.sv
// Per-bank power FSM: idle timer into light-sleep, timed wake-up, global shutdown.
//   state   | meaning
//   ST_ACT  | bank accepts requests, idle counter runs
//   ST_SLP  | light-sleep, macro ls=1
//   ST_WAKE | leaving sleep/shutdown, wake counter runs, not ready
//   ST_SD   | global shutdown, macro sd=1
module e203_dtcm_bank_pwr
  import e203_dtcm_bank_ram_pkg::*;
#(
  parameter int IDLE_CYC = E203_DTCM_IDLE_CYC,
  parameter int WAKE_CYC = E203_DTCM_WAKE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sd,
  input  logic req,
  output logic act,
  output logic ls,
  output logic sd_mac
);

  localparam int IW = cnt_w(IDLE_CYC);
  localparam int WW = cnt_w(WAKE_CYC);

  bank_st_e      state;
  logic [IW-1:0] idle_cnt;
  logic [WW-1:0] wake_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ACT;
      idle_cnt <= '0;
      wake_cnt <= '0;
      act      <= 1'b1;
      ls       <= 1'b0;
      sd_mac   <= 1'b0;
    end else if (sd) begin
      state  <= ST_SD;
      act    <= 1'b0;
      ls     <= 1'b0;
      sd_mac <= 1'b1;
    end else begin
      case (state)
        ST_ACT: begin
          // A request on the threshold cycle keeps the bank awake.
          if (req) begin
            idle_cnt <= '0;
          end else if (IDLE_CYC > 0 && idle_cnt == IW'(IDLE_CYC - 1)) begin
            state <= ST_SLP;
            act   <= 1'b0;
            ls    <= 1'b1;
          end else if (idle_cnt != IW'(IDLE_CYC)) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_SLP: begin
          if (req) begin
            state    <= ST_WAKE;
            wake_cnt <= '0;
            ls       <= 1'b0;
          end
        end
        ST_WAKE: begin
          if (wake_cnt == WW'(WAKE_CYC - 1)) begin
            state    <= ST_ACT;
            idle_cnt <= '0;
            act      <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end
        ST_SD: begin
          state    <= ST_WAKE;
          wake_cnt <= '0;
          sd_mac   <= 1'b0;
        end
        default: state <= ST_ACT;
      endcase
    end
  end

endmodule

// File: rtl/sirv_gnrl_ram.sv
// Behavioural single-port SRAM macro with byte mask, synchronous read and power pins.
module sirv_gnrl_ram #(
  parameter int DP           = 512,
  parameter int DW           = 32,
  parameter int FORCE_X2ZERO = 1,
  parameter int MW           = 4,
  parameter int AW           = 9
) (
  input  logic          sd,
  input  logic          ds,
  input  logic          ls,
  input  logic          rst_n,
  input  logic          clk,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic [MW-1:0] wem,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DP];
  logic [DW-1:0] dout_r;
  logic          rd_seen;
  logic          en;

  // Any low-power mode blocks access; contents are retained.
  assign en = cs & ~sd & ~ds & ~ls;

  always_ff @(posedge clk) begin
    if (en & we) begin
      for (int i = 0; i < MW; i++) begin
        if (wem[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
      end
    end
    if (en & ~we) dout_r <= mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rd_seen <= 1'b0;
    else if (en & ~we)  rd_seen <= 1'b1;
  end

  assign dout = (FORCE_X2ZERO != 0 && !rd_seen) ? '0 : dout_r;

endmodule

// File: rtl/e203_dtcm_bank_ram.sv
// Word-interleaved multi-bank DTCM with valid/ready requests, registered read
// response and per-bank automatic light-sleep.
module e203_dtcm_bank_ram
  import e203_dtcm_bank_ram_pkg::*;
#(
  parameter int NB           = E203_DTCM_NB,
  parameter int DW           = 32,
  parameter int MW           = DW / 8,
  parameter int AW           = 14,
  parameter int IDLE_CYC     = E203_DTCM_IDLE_CYC,
  parameter int WAKE_CYC     = E203_DTCM_WAKE_CYC,
  parameter int FORCE_X2ZERO = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sd,
  input  logic          ds,
  input  logic          cs,
  output logic          ready,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [MW-1:0] wem,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          rsp_valid,
  output logic [NB-1:0] bank_ls
);

  localparam int BW  = $clog2(NB);
  localparam int SW  = (NB > 1) ? BW : 1;
  localparam int BAW = AW - BW;

  logic [SW-1:0]  bsel;
  logic [SW-1:0]  bsel_r;
  logic [BAW-1:0] baddr;
  logic [NB-1:0]  bank_act;
  logic [NB-1:0]  bank_sd;
  logic [DW-1:0]  bank_dout [NB];
  logic [DW-1:0]  dout_q;
  logic           acc;

  if (NB > 1) begin : g_sel
    assign bsel = addr[BW-1:0];
  end else begin : g_nosel
    assign bsel = '0;
  end

  assign baddr = addr[AW-1:BW];
  assign ready = bank_act[bsel] & ~sd;
  assign acc   = cs & ready;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic hit;
    assign hit = (bsel == SW'(b));

    e203_dtcm_bank_pwr #(
      .IDLE_CYC (IDLE_CYC),
      .WAKE_CYC (WAKE_CYC)
    ) u_pwr (
      .clk    (clk),
      .rst_n  (rst_n),
      .sd     (sd),
      .req    (cs & hit),
      .act    (bank_act[b]),
      .ls     (bank_ls[b]),
      .sd_mac (bank_sd[b])
    );

    // Global sd reaches the macro in the same cycle, ahead of the FSM register.
    sirv_gnrl_ram #(
      .DP           (1 << BAW),
      .DW           (DW),
      .FORCE_X2ZERO (FORCE_X2ZERO),
      .MW           (MW),
      .AW           (BAW)
    ) u_ram (
      .sd    (bank_sd[b] | sd),
      .ds    (ds),
      .ls    (bank_ls[b]),
      .rst_n (rst_n),
      .clk   (clk),
      .cs    (acc & hit),
      .we    (we),
      .addr  (baddr),
      .din   (din),
      .wem   (wem),
      .dout  (bank_dout[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      bsel_r    <= '0;
      dout_q    <= '0;
    end else begin
      rsp_valid <= acc & ~we;
      if (acc & ~we) bsel_r <= bsel;
      if (rsp_valid) dout_q <= bank_dout[bsel_r];
    end
  end

  // Outside a response cycle dout replays the last delivered word.
  assign dout = rsp_valid ? bank_dout[bsel_r] : dout_q;

  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (cs && !ready) |=> (cs && $stable({we, addr, wem, din})));

endmodule

// File: tb/tb_e203_dtcm_bank_ram.sv
// Directed bench for the banked DTCM: data path, byte mask, sleep/wake timing, shutdown, reset.
module tb_e203_dtcm_bank_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sd = 1'b0;
  logic        ds = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [13:0] addr = '0;
  logic [3:0]  wem = '0;
  logic [31:0] din = '0;
  logic        ready;
  logic        rsp_valid;
  logic [31:0] dout;
  logic [3:0]  bank_ls;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  e203_dtcm_bank_ram #(
    .NB(4), .DW(32), .MW(4), .AW(14), .IDLE_CYC(8), .WAKE_CYC(2), .FORCE_X2ZERO(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sd(sd), .ds(ds), .cs(cs), .ready(ready), .we(we),
    .addr(addr), .wem(wem), .din(din), .dout(dout), .rsp_valid(rsp_valid), .bank_ls(bank_ls)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [3:0] m, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wem = m; din = d;
    #1;
  endtask

  task automatic rd(input logic [13:0] a);
    cs = 1'b1; we = 1'b0; addr = a; wem = '0; din = '0;
    #1;
  endtask

  task automatic idle();
    cs = 1'b0; we = 1'b0;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_dout", dout, 32'h0);
    chk("reset_bank_ls", 32'(bank_ls), 32'h0);

    // c0..c3: full write, read, masked write, read back on bank 1
    nxt(); rst_n = 1'b1; wr(14'd5, 4'hF, 32'hDEADBEEF);
    chk("t1_wr_ready", 32'(ready), 32'd1);
    nxt(); rd(14'd5);
    chk("t1_rd_ready", 32'(ready), 32'd1);
    chk("t1_no_rsp_after_wr", 32'(rsp_valid), 32'd0);
    nxt(); wr(14'd5, 4'b0010, 32'h0000AB00);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_dout", dout, 32'hDEADBEEF);
    nxt(); rd(14'd5);
    chk("t2_rsp_dropped", 32'(rsp_valid), 32'd0);
    chk("t2_dout_hold", dout, 32'hDEADBEEF);

    // c4..c7: fill one word per bank; bank 3 is hit on its idle-threshold cycle
    nxt(); wr(14'd0, 4'hF, 32'h11110000);
    chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2_masked_dout", dout, 32'hDEADABEF);
    nxt(); wr(14'd1, 4'hF, 32'h22221111);
    nxt(); wr(14'd2, 4'hF, 32'h33332222);
    nxt(); wr(14'd3, 4'hF, 32'h44443333);
    chk("t3_b3_threshold_ready", 32'(ready), 32'd1);
    chk("t3_bank_ls_awake", 32'(bank_ls), 32'h0);

    // c8..c13: back-to-back reads across all banks
    nxt(); rd(14'd0);
    chk("t3_rd0_ready", 32'(ready), 32'd1);
    nxt(); rd(14'd1);
    chk("t3_rd1_ready", 32'(ready), 32'd1);
    chk("t3_rsp0", 32'(rsp_valid), 32'd1);
    chk("t3_dout0", dout, 32'h11110000);
    nxt(); rd(14'd2);
    chk("t3_rd2_ready", 32'(ready), 32'd1);
    chk("t3_rsp1", 32'(rsp_valid), 32'd1);
    chk("t3_dout1", dout, 32'h22221111);
    nxt(); rd(14'd3);
    chk("t3_rd3_ready", 32'(ready), 32'd1);
    chk("t3_rsp2", 32'(rsp_valid), 32'd1);
    chk("t3_dout2", dout, 32'h33332222);
    nxt(); idle();
    chk("t3_rsp3", 32'(rsp_valid), 32'd1);
    chk("t3_dout3", dout, 32'h44443333);
    nxt(); idle();
    chk("t3_rsp_end", 32'(rsp_valid), 32'd0);
    chk("t3_dout_hold", dout, 32'h44443333);

    // c14..c19: banks fall asleep 8 idle cycles after their last request
    repeat (4) begin nxt(); idle(); end
    nxt(); idle();
    chk("t4_ls_c18", 32'(bank_ls), 32'h3);
    nxt(); idle();
    chk("t4_ls_c19", 32'(bank_ls), 32'h7);

    // c20..c24: read to sleeping bank 2 accepted after WAKE_CYC+1 cycles
    nxt(); rd(14'd2);
    chk("t4_ls_c20", 32'(bank_ls), 32'hF);
    chk("t4_ready_T", 32'(ready), 32'd0);
    nxt();
    chk("t4_ls_wake", 32'(bank_ls), 32'hB);
    chk("t4_ready_T1", 32'(ready), 32'd0);
    nxt();
    chk("t4_ready_T2", 32'(ready), 32'd0);
    chk("t4_no_rsp_while_wake", 32'(rsp_valid), 32'd0);
    nxt();
    chk("t4_ready_T3", 32'(ready), 32'd1);
    nxt(); idle();
    chk("t4_rsp", 32'(rsp_valid), 32'd1);
    chk("t4_dout", dout, 32'h33332222);

    // c25..c29: wake bank 0
    nxt(); rd(14'd0);
    chk("t5_wake_ready0", 32'(ready), 32'd0);
    nxt(); nxt();
    chk("t5_wake_ready2", 32'(ready), 32'd0);
    nxt();
    chk("t5_wake_accept", 32'(ready), 32'd1);
    nxt(); idle();
    chk("t5_wake_dout", dout, 32'h11110000);

    // c30..c37: request on bank 0's threshold cycle keeps it awake
    repeat (6) begin nxt(); idle(); end
    nxt(); rd(14'd0);
    chk("t5_thr_ls", 32'(bank_ls), 32'hE);
    chk("t5_thr_ready", 32'(ready), 32'd1);
    nxt(); idle();
    chk("t5_thr_rsp", 32'(rsp_valid), 32'd1);
    chk("t5_thr_dout", dout, 32'h11110000);
    chk("t5_thr_ls_after", 32'(bank_ls), 32'hE);

    // c38..c47: global shutdown with a held read, then two wake cycles
    nxt(); sd = 1'b1; rd(14'd1);
    chk("t6_sd_ready", 32'(ready), 32'd0);
    nxt();
    chk("t6_sd_ls", 32'(bank_ls), 32'h0);
    chk("t6_sd_ready1", 32'(ready), 32'd0);
    nxt(); nxt(); nxt();
    chk("t6_sd_ready4", 32'(ready), 32'd0);
    chk("t6_sd_no_rsp", 32'(rsp_valid), 32'd0);
    nxt(); sd = 1'b0; #1;
    chk("t6_sd_fall_ready", 32'(ready), 32'd0);
    nxt();
    chk("t6_wake1_ready", 32'(ready), 32'd0);
    nxt();
    chk("t6_wake2_ready", 32'(ready), 32'd0);
    nxt();
    chk("t6_accept_ready", 32'(ready), 32'd1);
    nxt(); idle();
    chk("t6_rsp", 32'(rsp_valid), 32'd1);
    chk("t6_dout", dout, 32'h22221111);

    // c48..c49: reset while a read response is being presented
    nxt(); rd(14'd3);
    chk("t6_rst_rd_ready", 32'(ready), 32'd1);
    nxt(); idle();
    chk("t6_pre_rst_rsp", 32'(rsp_valid), 32'd1);
    chk("t6_pre_rst_dout", dout, 32'h44443333);
    rst_n = 1'b0; #1;
    chk("t6_rst_rsp", 32'(rsp_valid), 32'd0);
    chk("t6_rst_dout", dout, 32'h0);
    chk("t6_rst_ready", 32'(ready), 32'd1);
    nxt(); rst_n = 1'b1; #1;
    chk("t6_post_rst_rsp", 32'(rsp_valid), 32'd0);
    chk("t6_post_rst_dout", dout, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
